prog_loader: RTL

Byte-stream program loader for the pipelined CPU's instruction memory. It receives a framed program image over a byte valid/ready stream and assembles big-endian 32-bit instruction words. It writes them sequentially into the instruction memory write port and holds the CPU (PC and IF/ID stalled) until the image is complete and verified. It is the writer-side counterpart of the instruction fetch path that reads the same memory.

---
 rtl/prog_loader_pkg.sv | 26 ++
 rtl/prog_loader_word_assembler.sv | 48 ++++
 rtl/prog_loader.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
package prog_loader_pkg;

  localparam int unsigned INSTR_W = 32;

  // Frame layout in bytes: length header, bytes per instruction word, trailer.
  localparam int unsigned LEN_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned CSUM_BYTES = 1;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StLenHi = 3'd1;
  localparam state_t StLenLo = 3'd2;
  localparam state_t StData  = 3'd3;
  localparam state_t StCsum  = 3'd4;
  localparam state_t StDone  = 3'd5;
  localparam state_t StErr   = 3'd6;

  // States in which the loader consumes stream bytes.
  function automatic logic is_loading(input state_t s);
    return (s == StLenHi) || (s == StLenLo) || (s == StData) || (s == StCsum);
  endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Collects big-endian bytes into 32-bit instruction words.
module prog_loader_word_assembler
  import prog_loader_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [7:0]         byte_i,
  output logic [INSTR_W-1:0] word_o,
  output logic               word_valid_o
);

  // Only the first three bytes need storage; the fourth is taken straight from byte_i.
  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  // Shift accepted bytes in MSB first and count position within the word.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (en_i) begin
      shift_d = {shift_q[15:0], byte_i};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  // Word output and strobe for the fourth byte.
  always_comb begin
    word_o       = {shift_q, byte_i};
    word_valid_o = en_i && !clr_i && (cnt_q == 2'(WORD_BYTES - 1));
  end

  // Assembly state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader that fills instruction memory and holds the CPU until verified.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               err
);

  localparam logic [16:0] DepthW = 17'(DEPTH);

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [INSTR_W-1:0]  wdata_q, wdata_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [7:0]          csum_q, csum_d;
  logic [7:0]          len_hi_q, len_hi_d;
  logic [15:0]         last_q, last_d;
  logic [15:0]         wcnt_q, wcnt_d;

  logic                accept;
  logic                load_start;
  logic [15:0]         len_w;
  logic                asm_en;
  logic [INSTR_W-1:0]  asm_word;
  logic                asm_valid;

  // Handshake, restart detection and the full word count once LEN_LO arrives.
  always_comb begin
    accept     = byte_valid && ready_q;
    load_start = start && !is_loading(state_q);
    len_w      = {len_hi_q, byte_in};
    asm_en     = accept && (state_q == StData);
  end

  prog_loader_word_assembler u_asm (
    .clk_i        (CLK),
    .rst_ni       (RESET),
    .clr_i        (load_start),
    .en_i         (asm_en),
    .byte_i       (byte_in),
    .word_o       (asm_word),
    .word_valid_o (asm_valid)
  );

  // Frame FSM, running checksum, write sequencing and status flags.
  always_comb begin
    state_d  = state_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    hold_d   = hold_q;
    done_d   = done_q;
    err_d    = err_q;
    csum_d   = csum_q;
    len_hi_d = len_hi_q;
    last_d   = last_q;
    wcnt_d   = wcnt_q;

    // Address advances the cycle after each write strobe.
    if (we_q) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StLenHi;
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
          csum_d  = '0;
          addr_d  = '0;
          wcnt_d  = '0;
        end
      end
      StLenHi: begin
        if (accept) begin
          len_hi_d = byte_in;
          csum_d   = csum_q ^ byte_in;
          state_d  = StLenLo;
        end
      end
      StLenLo: begin
        if (accept) begin
          csum_d = csum_q ^ byte_in;
          wcnt_d = '0;
          last_d = len_w - 16'd1;
          if ({1'b0, len_w} > DepthW) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else if (len_w == 16'd0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          csum_d = csum_q ^ byte_in;
          if (asm_valid) begin
            we_d    = 1'b1;
            wdata_d = asm_word;
            if (wcnt_q == last_q) begin
              state_d = StCsum;
            end else begin
              wcnt_d = wcnt_q + 16'd1;
            end
          end
        end
      end
      StCsum: begin
        if (accept) begin
          if (byte_in == csum_q) begin
            state_d = StDone;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    ready_d = is_loading(state_d);
  end

  // All loader state; reset takes effect immediately.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= StIdle;
      ready_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      hold_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      csum_q   <= '0;
      len_hi_q <= '0;
      last_q   <= '0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      err_q    <= err_d;
      csum_q   <= csum_d;
      len_hi_q <= len_hi_d;
      last_q   <= last_d;
      wcnt_q   <= wcnt_d;
    end
  end

  // Registered outputs.
  always_comb begin
    byte_ready = ready_q;
    im_we      = we_q;
    im_addr    = addr_q;
    im_wdata   = wdata_q;
    cpu_hold   = hold_q;
    done       = done_q;
    err        = err_q;
  end

endmodule
